// File: rtl/pcie_status_reporter.sv
// rtl/pcie_status_reporter.sv - interrupt-cause snapshot engine feeding the egress control FIFO; optional watchdog via STATUS_REPORT_TIMEOUT_EN
module pcie_status_reporter #(
  parameter int REG_COUNT = 9,
  parameter int CAUSE_COUNT = 4,
  parameter logic [CAUSE_COUNT*8-1:0] MSI_VECTORS = {8'h03, 8'h02, 8'h01, 8'h00},
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_cmd_rst_stb,
  input  logic [CAUSE_COUNT-1:0]   i_cause_stb,
  input  logic [REG_COUNT*32-1:0]  i_reg_map,
  input  logic [31:0]              i_status_addr,
  input  logic                     i_data_busy,
  input  logic [1:0]               i_fifo_rdy,
  output logic [1:0]               o_fifo_act,
  input  logic [23:0]              i_fifo_size,
  output logic                     o_fifo_stb,
  output logic [31:0]              o_fifo_data,
  output logic                     o_egress_enable,
  input  logic                     i_egress_finished,
  output logic [7:0]               o_egress_tlp_command,
  output logic [31:0]              o_egress_tlp_address,
  output logic                     o_cntrl_fifo_select,
  output logic                     o_interrupt_stb,
  output logic [7:0]               o_interrupt_msi_value,
  output logic [CAUSE_COUNT-1:0]   o_pending,
  output logic [7:0]               o_snapshot_count,
  output logic                     o_truncated,
`ifdef STATUS_REPORT_TIMEOUT_EN
  output logic [7:0]               o_timeout_count,
`endif
  output logic                     o_busy
);

  localparam logic [7:0] PCIE_MWR_32B = 8'h40;
  localparam int CW = $clog2(REG_COUNT + 1);

  typedef enum logic [2:0] {IDLE, WAIT_BUF, LOAD, SEND, IRQ} state_t;

  state_t                 state, state_next;
  logic [CW-1:0]          count;
  logic [CW-1:0]          limit;
  logic                   size_short;
  logic [2:0]             cur_cause;
  logic [2:0]             first_cause;
  logic [CAUSE_COUNT-1:0] pend_clr;
  logic                   timed_out;
  logic [31:0]            words [2**CW];

  // Map words are padded to a power of two so any counter value indexes safely.
  for (genvar k = 0; k < 2**CW; k++) begin : g_words
    if (k < REG_COUNT) begin : g_live
      assign words[k] = i_reg_map[32*k +: 32];
    end else begin : g_pad
      assign words[k] = '0;
    end
  end

  assign size_short           = i_fifo_size < 24'(REG_COUNT);
  assign limit                = size_short ? i_fifo_size[CW-1:0] : CW'(REG_COUNT);
  assign o_egress_tlp_command = PCIE_MWR_32B;
  assign o_busy               = (state != IDLE);
  assign o_fifo_data          = o_fifo_stb ? words[count] : 32'h0;

  // Lowest-index pending cause, and the one-hot clear issued when IDLE claims it.
  always_comb begin
    first_cause = '0;
    pend_clr    = '0;
    for (int i = CAUSE_COUNT - 1; i >= 0; i--) begin
      if (o_pending[i]) first_cause = 3'(i);
    end
    for (int i = 0; i < CAUSE_COUNT; i++) begin
      pend_clr[i] = (state == IDLE) && (|o_pending) && (first_cause == 3'(i));
    end
  end

`ifdef STATUS_REPORT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcount;

  assign timed_out = (state == SEND) && !i_egress_finished &&
                     (tcount == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts SEND cycles and tallies expirations (saturating).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcount          <= '0;
      o_timeout_count <= '0;
    end else if (i_cmd_rst_stb) begin
      tcount          <= '0;
      o_timeout_count <= '0;
    end else begin
      tcount <= (state == SEND) ? tcount + 1'b1 : '0;
      if (timed_out && o_timeout_count != 8'hFF) o_timeout_count <= o_timeout_count + 8'd1;
    end
  end
`else
  wire unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timed_out = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                state <= IDLE;
    else if (i_cmd_rst_stb) state <= IDLE;
    else                    state <= state_next;
  end

  // Next-state decode and per-state strobes.
  always_comb begin
    state_next      = state;
    o_fifo_stb      = 1'b0;
    o_egress_enable = 1'b0;
    o_interrupt_stb = 1'b0;
    case (state)
      IDLE: begin
        if (|o_pending) state_next = WAIT_BUF;
      end
      WAIT_BUF: begin
        if (o_cntrl_fifo_select && (|i_fifo_rdy) && (o_fifo_act == 2'b00)) state_next = LOAD;
      end
      LOAD: begin
        if (count >= limit) state_next = SEND;
        else                o_fifo_stb = 1'b1;
      end
      SEND: begin
        o_egress_enable = 1'b1;
        if (i_egress_finished || timed_out) state_next = IRQ;
      end
      IRQ: begin
        o_interrupt_stb = 1'b1;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: pending causes, buffer grant, word counter, status and MSI value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_pending             <= '0;
      cur_cause             <= '0;
      count                 <= '0;
      o_fifo_act            <= 2'b00;
      o_cntrl_fifo_select   <= 1'b0;
      o_egress_tlp_address  <= '0;
      o_interrupt_msi_value <= MSI_VECTORS[7:0];
      o_snapshot_count      <= '0;
      o_truncated           <= 1'b0;
    end else if (i_cmd_rst_stb) begin
      o_pending             <= '0;
      cur_cause             <= '0;
      count                 <= '0;
      o_fifo_act            <= 2'b00;
      o_cntrl_fifo_select   <= 1'b0;
      o_egress_tlp_address  <= '0;
      o_interrupt_msi_value <= MSI_VECTORS[7:0];
      o_snapshot_count      <= '0;
      o_truncated           <= 1'b0;
    end else begin
      // A new strobe outranks the clear of the same bit.
      o_pending <= (o_pending & ~pend_clr) | i_cause_stb;
      case (state)
        IDLE: begin
          if (|o_pending) begin
            cur_cause            <= first_cause;
            o_egress_tlp_address <= i_status_addr;
          end
        end
        WAIT_BUF: begin
          if (!i_data_busy) o_cntrl_fifo_select <= 1'b1;
          if (o_cntrl_fifo_select && (|i_fifo_rdy) && (o_fifo_act == 2'b00)) begin
            o_fifo_act <= i_fifo_rdy[0] ? 2'b01 : 2'b10;
            count      <= '0;
          end
        end
        LOAD: begin
          if (size_short) o_truncated <= 1'b1;
          if (count >= limit) o_fifo_act <= 2'b00;
          else                count      <= count + 1'b1;
        end
        SEND: begin
          if (i_egress_finished) begin
            o_snapshot_count      <= o_snapshot_count + 8'd1;
            o_interrupt_msi_value <= MSI_VECTORS[{cur_cause, 3'b000} +: 8];
          end else if (timed_out) begin
            o_interrupt_msi_value <= 8'hFF;
          end
        end
        IRQ: begin
          o_cntrl_fifo_select <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_status_reporter.sv
// tb/tb_pcie_status_reporter.sv - scoreboard bench for pcie_status_reporter
module tb_pcie_status_reporter;

  localparam int REG_COUNT = 9;
  localparam int CAUSE_COUNT = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    i_cmd_rst_stb = 1'b0;
  logic [CAUSE_COUNT-1:0]  i_cause_stb = '0;
  logic [REG_COUNT*32-1:0] i_reg_map;
  logic [31:0]             i_status_addr = 32'h1000_0040;
  logic                    i_data_busy = 1'b0;
  logic [1:0]              i_fifo_rdy = 2'b01;
  logic [1:0]              o_fifo_act;
  logic [23:0]             i_fifo_size = 24'd16;
  logic                    o_fifo_stb;
  logic [31:0]             o_fifo_data;
  logic                    o_egress_enable;
  logic                    i_egress_finished = 1'b0;
  logic [7:0]              o_egress_tlp_command;
  logic [31:0]             o_egress_tlp_address;
  logic                    o_cntrl_fifo_select;
  logic                    o_interrupt_stb;
  logic [7:0]              o_interrupt_msi_value;
  logic [CAUSE_COUNT-1:0]  o_pending;
  logic [7:0]              o_snapshot_count;
  logic                    o_truncated;
  logic                    o_busy;
`ifdef STATUS_REPORT_TIMEOUT_EN
  logic [7:0]              o_timeout_count;
`endif

  pcie_status_reporter #(
    .REG_COUNT(REG_COUNT), .CAUSE_COUNT(CAUSE_COUNT),
    .MSI_VECTORS({8'h03, 8'h02, 8'h01, 8'h00}), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .i_cmd_rst_stb(i_cmd_rst_stb), .i_cause_stb(i_cause_stb),
    .i_reg_map(i_reg_map), .i_status_addr(i_status_addr), .i_data_busy(i_data_busy),
    .i_fifo_rdy(i_fifo_rdy), .o_fifo_act(o_fifo_act), .i_fifo_size(i_fifo_size),
    .o_fifo_stb(o_fifo_stb), .o_fifo_data(o_fifo_data), .o_egress_enable(o_egress_enable),
    .i_egress_finished(i_egress_finished), .o_egress_tlp_command(o_egress_tlp_command),
    .o_egress_tlp_address(o_egress_tlp_address), .o_cntrl_fifo_select(o_cntrl_fifo_select),
    .o_interrupt_stb(o_interrupt_stb), .o_interrupt_msi_value(o_interrupt_msi_value),
    .o_pending(o_pending), .o_snapshot_count(o_snapshot_count), .o_truncated(o_truncated),
`ifdef STATUS_REPORT_TIMEOUT_EN
    .o_timeout_count(o_timeout_count),
`endif
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int irq_seen = 0;
  int en_len = 0;
  int last_en_len = 0;
  bit auto_finish = 1'b1;
  logic [31:0] exp_data [$];
  logic [7:0]  exp_irq [$];

  function automatic logic [31:0] word_val(input int k);
    return 32'hC0DE_0000 + 32'(k) * 32'h0000_0111;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_snapshot(input int n, input bit with_irq, input logic [7:0] msi);
    for (int k = 0; k < n; k++) exp_data.push_back(word_val(k));
    if (with_irq) exp_irq.push_back(msi);
  endtask

  task automatic strobe_cause(input logic [CAUSE_COUNT-1:0] c);
    @(negedge clk);
    i_cause_stb = c;
    @(negedge clk);
    i_cause_stb = '0;
  endtask

  task automatic wait_irqs(input int n, input int budget, input string name);
    int target;
    target = irq_seen + n;
    for (int i = 0; i < budget && irq_seen < target; i++) @(negedge clk);
    check(name, 32'(irq_seen >= target), 32'd1);
    @(negedge clk);
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT writes the FIFO or fires an MSI.
  initial begin
    logic [31:0] e;
    logic [7:0]  m;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_fifo_stb) begin
          if (exp_data.size() == 0) begin
            checks++; errors++;
            $display("FAIL fifo_data: got unexpected write %h expected none", o_fifo_data);
          end else begin
            e = exp_data.pop_front();
            check("fifo_data", o_fifo_data, e);
          end
        end
        if (o_egress_enable) en_len++;
        if (o_interrupt_stb) begin
          if (exp_irq.size() == 0) begin
            checks++; errors++;
            $display("FAIL msi_value: got unexpected interrupt %h expected none", o_interrupt_msi_value);
          end else begin
            m = exp_irq.pop_front();
            check("msi_value", 32'(o_interrupt_msi_value), 32'(m));
          end
          irq_seen++;
          last_en_len = en_len;
          en_len = 0;
        end
      end
    end
  end

  // Egress responder: finishes on the third enabled cycle when auto_finish is set.
  initial begin
    int en_cycles;
    en_cycles = 0;
    forever begin
      @(negedge clk);
      if (o_egress_enable && auto_finish) begin
        en_cycles++;
        i_egress_finished = (en_cycles == 3);
      end else begin
        en_cycles = 0;
        i_egress_finished = 1'b0;
      end
    end
  end

  initial begin
    int base;
    bit bad;
    for (int k = 0; k < REG_COUNT; k++) i_reg_map[32*k +: 32] = word_val(k);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_act", 32'(o_fifo_act), 32'd0);
    check("rst_pending", 32'(o_pending), 32'd0);
    check("rst_select", 32'(o_cntrl_fifo_select), 32'd0);
    check("rst_msi", 32'(o_interrupt_msi_value), 32'h00);
    check("rst_count", 32'(o_snapshot_count), 32'd0);
    rst = 1'b0;

    // Single cause 1, buffer 0, full map
    i_fifo_rdy = 2'b01; i_fifo_size = 24'd16;
    push_snapshot(9, 1'b1, 8'h01);
    strobe_cause(4'b0010);
    check("t1_pending", 32'(o_pending), 32'b0010);
    @(negedge clk);
    check("t1_waitbuf_busy", 32'(o_busy), 32'd1);
    check("t1_pending_claimed", 32'(o_pending), 32'd0);
    @(negedge clk);
    check("t1_no_early_stb", 32'(o_fifo_stb), 32'd0);
    @(negedge clk);
    check("t1_first_stb", 32'(o_fifo_stb), 32'd1);
    check("t1_act", 32'(o_fifo_act), 32'b01);
    check("t1_select", 32'(o_cntrl_fifo_select), 32'd1);
    i_status_addr = 32'hDEAD_BEEF;
    wait_irqs(1, 100, "t1_irq_timeout");
    check("t1_addr", o_egress_tlp_address, 32'h1000_0040);
    check("t1_en_len", 32'(last_en_len), 32'd3);
    check("t1_snap_count", 32'(o_snapshot_count), 32'd1);
    check("t1_truncated", 32'(o_truncated), 32'd0);
    check("t1_queue_empty", 32'(exp_data.size()), 32'd0);

    // Causes 2 and 0 together: cause 0 first
    push_snapshot(9, 1'b1, 8'h00);
    push_snapshot(9, 1'b1, 8'h02);
    base = irq_seen;
    strobe_cause(4'b0101);
    wait_irqs(2, 200, "t2_irq_timeout");
    repeat (20) @(negedge clk);
    check("t2_irq_total", 32'(irq_seen - base), 32'd2);
    check("t2_snap_count", 32'(o_snapshot_count), 32'd3);
    check("t2_queue_empty", 32'(exp_data.size() + exp_irq.size()), 32'd0);

    // Data path busy for 50 cycles, then buffer 1
    i_data_busy = 1'b1; i_fifo_rdy = 2'b10;
    push_snapshot(9, 1'b1, 8'h03);
    strobe_cause(4'b1000);
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (o_fifo_act != 2'b00 || o_cntrl_fifo_select) bad = 1'b1;
    end
    check("t3_idle_while_busy", 32'(bad), 32'd0);
    i_data_busy = 1'b0;
    for (int i = 0; i < 10 && o_fifo_act == 2'b00; i++) @(negedge clk);
    check("t3_act_buf1", 32'(o_fifo_act), 32'b10);
    wait_irqs(1, 100, "t3_irq_timeout");
    check("t3_snap_count", 32'(o_snapshot_count), 32'd4);

    // Small buffer: truncated snapshot still interrupts
    i_fifo_rdy = 2'b01; i_fifo_size = 24'd4;
    push_snapshot(4, 1'b1, 8'h01);
    strobe_cause(4'b0010);
    wait_irqs(1, 100, "t4_irq_timeout");
    check("t4_truncated", 32'(o_truncated), 32'd1);
    check("t4_queue_empty", 32'(exp_data.size()), 32'd0);
    check("t4_snap_count", 32'(o_snapshot_count), 32'd5);

    // In-band reset during LOAD word 3
    i_fifo_size = 24'd16;
    push_snapshot(4, 1'b0, 8'h00);
    base = irq_seen;
    strobe_cause(4'b0001);
    i_cause_stb = 4'b0100;
    @(negedge clk);
    i_cause_stb = '0;
    for (int i = 0; i < 20 && !(o_fifo_stb && o_fifo_data == word_val(3)); i++) @(negedge clk);
    check("t5_reached_word3", 32'(o_fifo_stb), 32'd1);
    i_cmd_rst_stb = 1'b1;
    @(negedge clk);
    i_cmd_rst_stb = 1'b0;
    check("t5_idle", 32'(o_busy), 32'd0);
    check("t5_act_dropped", 32'(o_fifo_act), 32'd0);
    check("t5_pending_clr", 32'(o_pending), 32'd0);
    check("t5_msi_reset", 32'(o_interrupt_msi_value), 32'h00);
    check("t5_snap_reset", 32'(o_snapshot_count), 32'd0);
    check("t5_trunc_reset", 32'(o_truncated), 32'd0);
    repeat (30) @(negedge clk);
    check("t5_no_irq", 32'(irq_seen - base), 32'd0);
    check("t5_queue_empty", 32'(exp_data.size()), 32'd0);

`ifdef STATUS_REPORT_TIMEOUT_EN
    // Egress never finishes: watchdog fires with MSI FF
    auto_finish = 1'b0;
    push_snapshot(9, 1'b1, 8'hFF);
    strobe_cause(4'b0010);
    wait_irqs(1, 100, "t6_irq_timeout");
    check("t6_en_len", 32'(last_en_len), 32'd16);
    check("t6_timeout_count", 32'(o_timeout_count), 32'd1);
    check("t6_snap_count", 32'(o_snapshot_count), 32'd0);
    auto_finish = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcie_status_reporter.md
# pcie_status_reporter

Parametrised status-snapshot engine for the PCIe slave control path. It collects interrupt causes and copies a `REG_COUNT`-word register map into one buffer of the egress ping-pong FIFO. It then has the egress state machine issue a 32-bit memory write to the host status buffer and raises an MSI whose vector depends on the cause. It sits between the ingress command decoder and the egress TLP engine, and supersedes the fixed single-cause config reporter.

## Interface

- `REG_COUNT`, 9: number of 32-bit words per snapshot (1..31).
- `CAUSE_COUNT`, 4: number of independent interrupt causes (1..8).
- `MSI_VECTORS`, {8'h03,8'h02,8'h01,8'h00}: packed `CAUSE_COUNT`×8 MSI values; cause i uses bits [8i+7:8i].
- `TIMEOUT_CYCLES`, 1024: egress watchdog limit (used only with the timeout feature).
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `i_cmd_rst_stb`  in  1  in-band reset; synchronous, same effect as `rst`.
- `i_cause_stb`  in  `CAUSE_COUNT`  per-cause request strobes (ping, read-config, buffer update, …).
- `i_reg_map`  in  `REG_COUNT`×32  flat register map; word k is [32k+31:32k].
- `i_status_addr`  in  32  host status buffer address.
- `i_data_busy`  in  1  data-path state machine owns egress; snapshot must not start.
- `i_fifo_rdy`  in  2  ping-pong FIFO write ready.
- `o_fifo_act`  out  2  FIFO write activate.
- `i_fifo_size`  in  24  FIFO write size.
- `o_fifo_stb`  out  1  write strobe.
- `o_fifo_data`  out  32  write data.
- `o_egress_enable`  out  1  request egress transmission.
- `i_egress_finished`  in  1  egress done.
- `o_egress_tlp_command`  out  8  constant `PCIE_MWR_32B`.
- `o_egress_tlp_address`  out  32  `i_status_addr`, sampled at snapshot start.
- `o_cntrl_fifo_select`  out  1  routes egress to the control FIFO.
- `o_interrupt_stb`  out  1  one-cycle MSI strobe.
- `o_interrupt_msi_value`  out  8  vector for the current strobe.
- `o_pending`  out  `CAUSE_COUNT`  sticky pending causes.
- `o_snapshot_count`  out  8  completed snapshots, wraps at 255→0.
- `o_truncated`  out  1  sticky; set when a FIFO buffer was smaller than `REG_COUNT`.
- `o_busy`  out  1  state ≠ IDLE.

## Operation

- Reset (`rst` async, or `i_cmd_rst_stb` sync): state IDLE, all outputs 0, `o_interrupt_msi_value` = vector of cause 0, `o_pending` cleared.
- `o_pending[i]` is set by `i_cause_stb[i]`. A set in the same cycle as a clear of that bit wins.
- States:
  - IDLE: if `o_pending` ≠ 0, latch the lowest-index pending cause into `cur_cause`, clear its pending bit, latch `i_status_addr`, go to WAIT_BUF.
  - WAIT_BUF: when `!i_data_busy`, assert `o_cntrl_fifo_select`. When `i_fifo_rdy` ≠ 0 and `o_fifo_act` == 0, activate bit 0 if ready, otherwise bit 1. Clear the word counter and go to LOAD.
  - LOAD: one word per cycle, `o_fifo_data` = word[count], `o_fifo_stb` = 1. The limit is min(`REG_COUNT`, `i_fifo_size`). If the limit is below `REG_COUNT`, set `o_truncated`. At the limit, drop `o_fifo_act` and go to SEND.
  - SEND: hold `o_egress_enable` = 1 until `i_egress_finished`, then deassert, increment `o_snapshot_count`, go to IRQ.
  - IRQ: `o_interrupt_stb` = 1, `o_interrupt_msi_value` = `MSI_VECTORS[cur_cause]`, go to IDLE.
- Causes arriving during a snapshot remain pending. Repeated strobes of one cause coalesce into one snapshot.
- `o_cntrl_fifo_select` stays 1 from the WAIT_BUF grant through IRQ.

## Timing

- Cause strobe at cycle 0 with the engine idle: WAIT_BUF at cycle 2. If the buffer is ready and the data path is idle, the first `o_fifo_stb` is at cycle 4.
- LOAD takes exactly limit cycles of strobes plus 1 cycle for deactivation.
- Minimum gap from `i_egress_finished` to `o_interrupt_stb`: 1 cycle.
- Back-to-back snapshots are separated by at least one IDLE cycle.
- `i_cmd_rst_stb` mid-snapshot aborts immediately. No interrupt fires, and the FIFO activate drops the next cycle.

## Configuration

- `STATUS_REPORT_TIMEOUT_EN` defined: SEND counts cycles. At `TIMEOUT_CYCLES` without `i_egress_finished`, it deasserts `o_egress_enable`, skips the count increment, and goes to IRQ with `o_interrupt_msi_value` = 8'hFF. Port `o_timeout_count` (8, saturating) is present.
- Not defined: SEND waits indefinitely. There is no counter and no `o_timeout_count` port.

## Test plan

- Single cause 1, `i_fifo_rdy`=2'b01, size 16 → 9 strobes carrying words 0..8, `o_egress_enable` held until finished, `o_interrupt_stb` with value 8'h01, `o_snapshot_count`=1.
- Causes 2 and 0 strobed in the same cycle → cause 0 snapshot first (MSI 8'h00), then cause 2 (8'h02). Exactly two interrupts.
- `i_data_busy` held 50 cycles → no `o_fifo_act` until it drops. Then buffer 1 is used when `i_fifo_rdy`=2'b10.
- `i_fifo_size`=4 → 4 strobes, `o_truncated`=1, interrupt still delivered.
- `i_cmd_rst_stb` during LOAD word 3 → IDLE next cycle, no interrupt, `o_pending` cleared.
- With `STATUS_REPORT_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, finished never asserted → enable drops after 16 cycles, MSI 8'hFF, `o_timeout_count`=1.
